// File: rtl/clic_pkg.sv
// Shared types for the CLIC interrupt gateway.
// The trigger encoding matches the attr_trig field, read as {tpol, le}.
package clic_pkg;

  typedef enum logic [1:0] {
    TRIG_LEVEL_POS = 2'b00,
    TRIG_EDGE_POS  = 2'b01,
    TRIG_LEVEL_NEG = 2'b10,
    TRIG_EDGE_NEG  = 2'b11
  } trig_e;

  typedef enum logic {
    CLAIM_IDLE  = 1'b0,
    CLAIM_CLEAR = 1'b1
  } claim_state_e;

  function automatic logic trig_is_edge(input trig_e t);
    return (t == TRIG_EDGE_POS) || (t == TRIG_EDGE_NEG);
  endfunction

  function automatic logic trig_is_neg(input trig_e t);
    return (t == TRIG_LEVEL_NEG) || (t == TRIG_EDGE_NEG);
  endfunction

endpackage

// File: rtl/clic_gateway_cell.sv
// One interrupt source: input synchroniser, previous-sample flop, polarity-aware
// edge detect and the pending flop with edge > claim clear > software write priority.
module clic_gateway_cell
  import clic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic le_i,
  input  logic tpol_i,
  input  logic clr_i,
  input  logic sw_we_i,
  input  logic sw_d_i,
  output logic ip_o
);

  trig_e trig;
  logic  s;
  logic  prev_q;
  logic  pol;
  logic  lvl;
  logic  edge_det;
  logic  ip_d;
  logic  ip_q;

  assign trig = trig_e'({tpol_i, le_i});
  assign pol  = trig_is_neg(trig);

  // Synchroniser stages; depth 0 means the line is already in this clock domain.
  if (SYNC_STAGES > 0) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= '0;
      else         sync_q <= (sync_q << 1) | SYNC_STAGES'(src_i);
    end
    assign s = sync_q[SYNC_STAGES-1];
  end else begin : g_bypass
    assign s = src_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b0;
    else         prev_q <= s;
  end

  // Both terms use the current polarity, so a polarity flip alone never looks like an edge.
  assign lvl      = s ^ pol;
  assign edge_det = lvl & ~(prev_q ^ pol);

  always_comb begin
    ip_d = ip_q;
    if (!trig_is_edge(trig)) ip_d = lvl;
    else if (edge_det)       ip_d = 1'b1;
    else if (clr_i)          ip_d = 1'b0;
    else if (sw_we_i)        ip_d = sw_d_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ip_q <= 1'b0;
    else         ip_q <= ip_d;
  end

  assign ip_o = ip_q;

endmodule

// File: rtl/clic_gateway.sv
// Per-source interrupt gateway producing the registered pending vector for the CLIC
// register adapter, plus the two-state claim FSM that clears edge-pending on acknowledge.
module clic_gateway
  import clic_pkg::*;
#(
  parameter int N_SOURCE    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_SOURCE-1:0]         intr_src_i,
  input  logic [N_SOURCE-1:0]         le_i,
  input  logic [N_SOURCE-1:0]         tpol_i,
  input  logic [N_SOURCE-1:0]         ip_sw_i,
  input  logic [N_SOURCE-1:0]         ip_sw_qe_i,
  input  logic                        claim_valid_i,
  input  logic [$clog2(N_SOURCE)-1:0] claim_id_i,
  output logic                        claim_ready_o,
  output logic [N_SOURCE-1:0]         ip_o
);

  localparam int SRC_W = $clog2(N_SOURCE);

  claim_state_e        state_q;
  claim_state_e        state_d;
  logic [SRC_W-1:0]    id_q;
  logic                clr_en;
  logic                accept;
  logic [N_SOURCE-1:0] clr_vec;

  assign accept = claim_valid_i & claim_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLAIM_IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) id_q <= claim_id_i;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLAIM_IDLE:  if (claim_valid_i) state_d = CLAIM_CLEAR;
      CLAIM_CLEAR: state_d = CLAIM_IDLE;
      default:     state_d = CLAIM_IDLE;
    endcase
  end

  always_comb begin
    claim_ready_o = (state_q == CLAIM_IDLE);
    clr_en        = (state_q == CLAIM_CLEAR);
  end

  // Ids at or above N_SOURCE match no cell, so such a claim completes without effect.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < N_SOURCE; i++) clr_vec[i] = clr_en && (int'(id_q) == i);
  end

  for (genvar i = 0; i < N_SOURCE; i++) begin : g_cell
    clic_gateway_cell #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cell (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .src_i   (intr_src_i[i]),
      .le_i    (le_i[i]),
      .tpol_i  (tpol_i[i]),
      .clr_i   (clr_vec[i]),
      .sw_we_i (ip_sw_qe_i[i]),
      .sw_d_i  (ip_sw_i[i]),
      .ip_o    (ip_o[i])
    );
  end

endmodule

// File: tb/tb_clic_gateway.sv
// Directed bench for clic_gateway: a per-cycle vector table plus hand sequences
// for back-to-back claims, out-of-range ids, bypassed sync and reset during CLEAR.
module tb_clic_gateway;

  localparam int N  = 32;
  localparam int NO = 20;
  localparam logic [N-1:0] LE0 = 32'h0000_00A4;
  localparam logic [N-1:0] LE3 = 32'h0000_00AC;
  localparam logic [N-1:0] TP0 = 32'h0000_0080;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [N-1:0] src, le, tpol, sw, swqe, ip;
  logic         cv, rdy;
  logic [4:0]   cid;

  logic [NO-1:0] o_src, o_le, o_tpol, o_sw, o_swqe, o_ip;
  logic          o_cv, o_rdy;
  logic [4:0]    o_cid;

  clic_gateway #(.N_SOURCE(N), .SYNC_STAGES(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .intr_src_i(src), .le_i(le), .tpol_i(tpol),
    .ip_sw_i(sw), .ip_sw_qe_i(swqe), .claim_valid_i(cv), .claim_id_i(cid),
    .claim_ready_o(rdy), .ip_o(ip)
  );

  clic_gateway #(.N_SOURCE(NO), .SYNC_STAGES(0)) u_odd (
    .clk_i(clk), .rst_ni(rst_n), .intr_src_i(o_src), .le_i(o_le), .tpol_i(o_tpol),
    .ip_sw_i(o_sw), .ip_sw_qe_i(o_swqe), .claim_valid_i(o_cv), .claim_id_i(o_cid),
    .claim_ready_o(o_rdy), .ip_o(o_ip)
  );

  typedef struct {
    string        name;
    logic [N-1:0] src, le, tpol, swqe, sw;
    logic         cv;
    logic [4:0]   cid;
    logic [N-1:0] exp_ip;
    logic         exp_rdy;
  } vec_t;

  vec_t tbl[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic row(input string nm, input logic [N-1:0] s, input logic [N-1:0] l,
                     input logic [N-1:0] t, input logic [N-1:0] q, input logic [N-1:0] d,
                     input logic v, input logic [4:0] id, input logic [N-1:0] e,
                     input logic r);
    vec_t x;
    x.name = nm; x.src = s; x.le = l; x.tpol = t; x.swqe = q; x.sw = d;
    x.cv = v; x.cid = id; x.exp_ip = e; x.exp_rdy = r;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: ip_o=%h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    row("idle",          32'h00, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("lvl3_rise_c1",  32'h08, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("lvl3_rise_c2",  32'h08, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("lvl3_rise_c3",  32'h08, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h08, 1'b1);
    row("lvl3_fall_c1",  32'h00, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h08, 1'b1);
    row("lvl3_fall_c2",  32'h00, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h08, 1'b1);
    row("lvl3_fall_c3",  32'h00, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("e5_pulse",      32'h20, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("e5_c2",         32'h00, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("e5_pend",       32'h00, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h20, 1'b1);
    row("e5_hold",       32'h00, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h20, 1'b1);
    row("e5_claim",      32'h00, LE0, TP0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h20, 1'b0);
    row("e5_cleared",    32'h00, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("n7_rise_c1",    32'h80, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("n7_rise_c2",    32'h80, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("n7_rise_c3",    32'h80, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("n7_fall_c1",    32'h00, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("n7_fall_c2",    32'h00, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("n7_fall_c3",    32'h00, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h80, 1'b1);
    row("n7_sw_clear",   32'h00, LE0, TP0, 32'h80, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("n7_tpol_lo",    32'h00, LE0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("n7_tpol_hi",    32'h00, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("n7_tpol_lo2",   32'h00, LE0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("n7_tpol_hi2",   32'h00, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("e2_rise",       32'h04, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00, 1'b1);
    row("e2_claim",      32'h04, LE0, TP0, 32'h0, 32'h0, 1'b1, 5'd2, 32'h00, 1'b0);
    row("e2_edge_vs_clr",32'h04, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h04, 1'b1);
    row("e2_hold",       32'h04, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h04, 1'b1);
    row("e2_sw0",        32'h04, LE0, TP0, 32'h04, 32'h00, 1'b0, 5'd0, 32'h00, 1'b1);
    row("e2_sw1",        32'h04, LE0, TP0, 32'h04, 32'h04, 1'b0, 5'd0, 32'h04, 1'b1);
    row("lvl3_sw_ignore",32'h04, LE0, TP0, 32'h08, 32'h08, 1'b0, 5'd0, 32'h04, 1'b1);
    row("m3_rise_c1",    32'h0C, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h04, 1'b1);
    row("m3_rise_c2",    32'h0C, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h04, 1'b1);
    row("m3_rise_c3",    32'h0C, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0C, 1'b1);
    row("m3_to_edge",    32'h0C, LE3, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0C, 1'b1);
    row("m3_fall_c1",    32'h04, LE3, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0C, 1'b1);
    row("m3_fall_c2",    32'h04, LE3, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0C, 1'b1);
    row("m3_fall_c3",    32'h04, LE3, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0C, 1'b1);
    row("m3_to_level",   32'h04, LE0, TP0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h04, 1'b1);

    rst_n = 1'b0;
    src = '0; le = LE0; tpol = TP0; sw = '0; swqe = '0; cv = 1'b0; cid = '0;
    o_src = '0; o_le = '1; o_tpol = '0; o_sw = '0; o_swqe = '0; o_cv = 1'b0; o_cid = '0;
    repeat (3) tick();
    chk("reset_ip", ip, 32'h0);
    chk1("reset_ready", rdy, 1'b1);
    chk({12'h0, o_ip}, {12'h0, o_ip} & 32'h0, 32'h0) ;
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      src = tbl[k].src; le = tbl[k].le; tpol = tbl[k].tpol;
      swqe = tbl[k].swqe; sw = tbl[k].sw; cv = tbl[k].cv; cid = tbl[k].cid;
      tick();
      chk(tbl[k].name, ip, tbl[k].exp_ip);
      chk1({tbl[k].name, "_rdy"}, rdy, tbl[k].exp_rdy);
    end

    // Back-to-back claims with valid held: ids 1 then 4 on edge sources.
    le = LE0 | 32'h12; swqe = 32'h12; sw = 32'h12;
    tick();
    chk("b2b_setup", ip, 32'h16);
    swqe = '0; sw = '0; cv = 1'b1; cid = 5'd1;
    tick();
    chk1("b2b_acc1_rdy", rdy, 1'b0);
    chk("b2b_acc1_ip", ip, 32'h16);
    tick();
    chk1("b2b_idle1_rdy", rdy, 1'b1);
    chk("b2b_clr1_ip", ip, 32'h14);
    cid = 5'd4;
    tick();
    chk1("b2b_acc2_rdy", rdy, 1'b0);
    tick();
    chk1("b2b_idle2_rdy", rdy, 1'b1);
    chk("b2b_clr4_ip", ip, 32'h04);
    cv = 1'b0; cid = '0;

    // Unsynchronised 20-source instance: one-cycle latency and out-of-range claim id.
    o_src = 20'h00001;
    tick();
    chk("odd_bypass_lat", {12'h0, o_ip}, 32'h1);
    o_swqe = 20'h00008; o_sw = 20'h00008;
    tick();
    chk("odd_sw_set", {12'h0, o_ip}, 32'h9);
    o_swqe = '0; o_sw = '0; o_cv = 1'b1; o_cid = 5'd25;
    tick();
    chk1("odd_oor_acc_rdy", o_rdy, 1'b0);
    o_cv = 1'b0;
    tick();
    chk1("odd_oor_idle_rdy", o_rdy, 1'b1);
    chk("odd_oor_noclr", {12'h0, o_ip}, 32'h9);
    o_cv = 1'b1; o_cid = 5'd3;
    tick();
    o_cv = 1'b0;
    tick();
    chk("odd_inrange_clr", {12'h0, o_ip}, 32'h1);

    // Reset asserted while the FSM sits in CLEAR.
    src = '0; swqe = 32'h20; sw = 32'h20;
    tick();
    chk("rst_setup", ip, 32'h24);
    swqe = '0; sw = '0; cv = 1'b1; cid = 5'd5;
    tick();
    chk1("rst_in_clear_rdy", rdy, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("rst_mid_ip", ip, 32'h0);
    chk1("rst_mid_rdy", rdy, 1'b1);
    cv = 1'b0; cid = '0;
    tick();
    chk("rst_hold_ip", ip, 32'h0);
    chk1("rst_hold_rdy", rdy, 1'b1);
    rst_n = 1'b1;
    swqe = 32'h20; sw = 32'h20;
    tick();
    chk("post_rst_sw_set", ip, 32'h20);
    swqe = '0; sw = '0;
    tick();
    chk("post_rst_no_clr", ip, 32'h20);
    chk1("post_rst_rdy", rdy, 1'b1);
    swqe = 32'h20;
    tick();
    chk("post_rst_sw_clr", ip, 32'h0);
    swqe = '0; src = 32'h20;
    tick();
    chk("fresh_edge_c1", ip, 32'h0);
    tick();
    chk("fresh_edge_c2", ip, 32'h0);
    tick();
    chk("fresh_edge_c3", ip, 32'h20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
